// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: NUM_RD combinational reads and two
// prioritised write ports. It also has an optional zero entry, write bypass and a background clear.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [WIDTH-1:0]           wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [WIDTH-1:0]           wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*WIDTH-1:0]    rd,
    input  logic                       clr_req,
    output logic                       busy
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W:0]   LAST_C = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               we0_ok, we1_ok;
    logic [ADDR_W-1:0]  addr_p;
    logic [WIDTH-1:0]   data_p;

    assign we0_ok = we0 && !((HAS_ZERO != 0) && (wa0 == ZERO_A));
    assign we1_ok = we1 && !((HAS_ZERO != 0) && (wa1 == ZERO_A));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = (state_q == CLEAR);
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + (ADDR_W + 1)'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Later assignments win: a pipeline write to the entry being cleared keeps its data,
    // and port 1 overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == CLEAR) mem_q[cnt_q[ADDR_W-1:0]] <= '0;
            if (we0_ok) mem_q[wa0] <= wd0;
            if (we1_ok) mem_q[wa1] <= wd1;
        end
    end

    always_comb begin
        rd     = '0;
        addr_p = '0;
        data_p = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            addr_p = ra[p*ADDR_W +: ADDR_W];
            data_p = mem_q[addr_p];
            if (BYPASS != 0) begin
                if (we1 && (wa1 == addr_p))      data_p = wd1;
                else if (we0 && (wa0 == addr_p)) data_p = wd0;
            end
            if ((HAS_ZERO != 0) && (addr_p == ZERO_A)) data_p = '0;
            rd[p*WIDTH +: WIDTH] = data_p;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
// Each task checks its own scenario inline against hand-computed values.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam logic [63:0] PAT = 64'h0000010204080001;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset, we0, we1, clr_req;
    logic [4:0]   wa0, wa1;
    logic [63:0]  wd0, wd1;
    logic [9:0]   ra;
    logic [127:0] rd, rd_nb;
    logic         busy, busy_nb;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .clr_req(clr_req), .busy(busy)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_nb), .clr_req(clr_req), .busy(busy_nb)
    );

    // Advance one cycle; inputs are driven 1ns after the edge, outputs read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] patOf(int k);
        return (k == 31) ? 64'h0 : 64'(k) * PAT;
    endfunction

    task automatic idleInputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        clr_req = 1'b0;
    endtask

    task automatic fillAll(input logic [63:0] val);
        for (int i = 0; i < 32; i++) begin
            we1 = 1'b1; wa1 = 5'(i); wd1 = val;
            tick();
        end
        we1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        ra = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %0b want 0", busy);
        end
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            vectors++;
            if (rd[63:0] !== 64'h0 || rd[127:64] !== 64'h0) begin
                errors++;
                $display("FAIL reset_read[%0d] got %h/%h want 0/0", i, rd[63:0], rd[127:64]);
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 31; i++) begin
            we1 = 1'b1; wa1 = 5'(i); wd1 = patOf(i);
            tick();
        end
        we1 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            vectors++;
            if (rd[63:0] !== patOf(i) || rd[127:64] !== patOf(31 - i)) begin
                errors++;
                $display("FAIL write_read[%0d] got %h/%h want %h/%h",
                         i, rd[63:0], rd[127:64], patOf(i), patOf(31 - i));
            end
        end
    endtask

    task automatic test_zero();
        ra = {5'd0, 5'd31};
        we1 = 1'b1; wa1 = 5'd31; wd1 = 64'hA0;
        #1;
        vectors++;
        if (rd[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL zero_same_cycle got %h want 0", rd[63:0]);
        end
        tick();
        we1 = 1'b0;
        #1;
        vectors++;
        if (rd[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL zero_after_edge got %h want 0", rd[63:0]);
        end
    endtask

    task automatic test_priority();
        ra = {5'd0, 5'd5};
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'h1111;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 64'h2222;
        #1;
        vectors++;
        if (rd[63:0] !== 64'h2222) begin
            errors++;
            $display("FAIL prio_bypass got %h want 2222", rd[63:0]);
        end
        vectors++;
        if (rd_nb[63:0] !== patOf(5)) begin
            errors++;
            $display("FAIL prio_nobypass_old got %h want %h", rd_nb[63:0], patOf(5));
        end
        tick();
        idleInputs();
        #1;
        vectors++;
        if (rd[63:0] !== 64'h2222 || rd_nb[63:0] !== 64'h2222) begin
            errors++;
            $display("FAIL prio_stored got %h/%h want 2222", rd[63:0], rd_nb[63:0]);
        end
        // Distinct addresses: both ports commit and each bypasses to its own reader.
        ra = {5'd8, 5'd6};
        we0 = 1'b1; wa0 = 5'd6; wd0 = 64'h3333;
        we1 = 1'b1; wa1 = 5'd8; wd1 = 64'h4444;
        #1;
        vectors++;
        if (rd[63:0] !== 64'h3333 || rd[127:64] !== 64'h4444) begin
            errors++;
            $display("FAIL dual_bypass got %h/%h want 3333/4444", rd[63:0], rd[127:64]);
        end
        tick();
        idleInputs();
        #1;
        vectors++;
        if (rd_nb[63:0] !== 64'h3333 || rd_nb[127:64] !== 64'h4444) begin
            errors++;
            $display("FAIL dual_stored got %h/%h want 3333/4444", rd_nb[63:0], rd_nb[127:64]);
        end
    endtask

    task automatic test_no_bypass();
        ra = {5'd0, 5'd7};
        we1 = 1'b1; wa1 = 5'd7; wd1 = 64'hDEAD;
        #1;
        vectors++;
        if (rd_nb[63:0] !== patOf(7)) begin
            errors++;
            $display("FAIL nobypass_old got %h want %h", rd_nb[63:0], patOf(7));
        end
        vectors++;
        if (rd[63:0] !== 64'hDEAD) begin
            errors++;
            $display("FAIL bypass_new got %h want dead", rd[63:0]);
        end
        tick();
        we1 = 1'b0;
        #1;
        vectors++;
        if (rd_nb[63:0] !== 64'hDEAD) begin
            errors++;
            $display("FAIL nobypass_next got %h want dead", rd_nb[63:0]);
        end
    endtask

    // Cycle c runs between edges c-1 and c after the pulse edge; entry k is zero from cycle k+2.
    task automatic test_clear();
        logic [63:0] exp0, exp1;
        logic        expBusy;
        fillAll(ONES);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            clr_req = (c == 5);
            we1 = (c == 11); wa1 = 5'd10; wd1 = 64'h55;
            ra = {5'((c - 1) & 31), 5'((c - 2) & 31)};
            #1;
            expBusy = (c <= 32);
            vectors++;
            if (busy !== expBusy) begin
                errors++;
                $display("FAIL clear_busy[c%0d] got %0b want %0b", c, busy, expBusy);
            end
            if (c >= 2 && c <= 33) begin
                exp0 = (c - 2 == 10) ? 64'h55 : 64'h0;
                vectors++;
                if (rd[63:0] !== exp0) begin
                    errors++;
                    $display("FAIL clear_zeroed[e%0d] got %h want %h", c - 2, rd[63:0], exp0);
                end
            end
            if (c <= 32) begin
                exp1 = (c - 1 == 31) ? 64'h0 : (c - 1 == 10 && c == 11) ? 64'h55 : ONES;
                vectors++;
                if (rd[127:64] !== exp1) begin
                    errors++;
                    $display("FAIL clear_pending[e%0d] got %h want %h", c - 1, rd[127:64], exp1);
                end
            end
            tick();
        end
        idleInputs();
        ra = {5'd0, 5'd10};
        #1;
        vectors++;
        if (rd[63:0] !== 64'h55 || rd[127:64] !== 64'h0) begin
            errors++;
            $display("FAIL clear_final got %h/%h want 55/0", rd[63:0], rd[127:64]);
        end
    endtask

    task automatic test_reset_mid_clear();
        fillAll(ONES);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_busy got %0b want 0", busy);
        end
        for (int i = 0; i < 16; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            vectors++;
            if (rd[63:0] !== 64'h0 || rd[127:64] !== 64'h0) begin
                errors++;
                $display("FAIL midclear_read[%0d] got %h/%h want 0/0", i, rd[63:0], rd[127:64]);
            end
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_busy_hold got %0b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero();
        test_priority();
        test_no_bypass();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 32x64 two-read/one-write datapath register file.
- Configurable width, depth and read-port count.
- Two write ports with fixed priority and optional write-to-read bypass.
- Optional hardwired-zero register.
- Background clear sequencer that zeroes the array one entry per cycle on request.
- Sits in the decode stage of the pipelined datapath; write port 1 is driven by writeback, write port 0 by the load/secondary return path.

Parameters:
- WIDTH, 64, bits per register.
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- HAS_ZERO, 1, when 1, entry ZERO_IDX always reads 0 and ignores writes.
- ZERO_IDX, 31, index of the hardwired-zero entry.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- we0, input, 1, write enable, port 0.
- wa0, input, ADDR_W, write address, port 0.
- wd0, input, WIDTH, write data, port 0.
- we1, input, 1, write enable, port 1 (higher priority).
- wa1, input, ADDR_W, write address, port 1.
- wd1, input, WIDTH, write data, port 1.
- ra, input, NUM_RD*ADDR_W, packed read addresses; port p is bits [p*ADDR_W +: ADDR_W].
- rd, output, NUM_RD*WIDTH, packed read data; port p is bits [p*WIDTH +: WIDTH].
- clr_req, input, 1, one-cycle pulse requesting a full array clear.
- busy, output, 1, high while the clear sequencer is active.

Behaviour:
- Reset:
  - reset high at a posedge zeroes all DEPTH entries, busy=0, clear counter=0; overrides everything.
  - rd is then 0 for every address, absent bypass.
- Reads:
  - Combinational, zero latency.
  - rd[p] = array[ra[p]], subject to the zero and bypass rules below.
- Writes:
  - Commit at posedge when we0/we1 are high.
  - we0 and we1 both high with wa0==wa1: wd1 is stored, wd0 dropped.
  - Distinct addresses: both commit in the same cycle.
- Zero entry (HAS_ZERO=1):
  - Writes to ZERO_IDX are discarded.
  - Reads of ZERO_IDX return 0 regardless of bypass or array content.
- Bypass (BYPASS=1), evaluated per read port, in priority order:
  - we1 && wa1==ra[p] → rd[p]=wd1.
  - else we0 && wa0==ra[p] → rd[p]=wd0.
  - else stored value.
  - BYPASS=0: reads return the pre-edge stored value; new data is visible the cycle after the write.
- Clear sequencer FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1 → CLEAR next cycle; counter=0; busy=1 from the following cycle.
  - In CLEAR, each posedge zeroes array[counter] and increments counter.
  - After entry DEPTH-1 is zeroed → IDLE, busy=0. busy is high for exactly DEPTH cycles.
  - clr_req=1 while in CLEAR is ignored; no restart, no queueing.
  - Pipeline writes stay enabled during CLEAR. A write to the entry being cleared in the same cycle wins: the entry holds the write data.
  - Clear writes are never bypassed; reads during CLEAR return the stored contents.
  - reset mid-clear: array zeroed, FSM → IDLE, busy=0 at that edge.
- Width rules: addresses are unsigned; no wrap beyond DEPTH-1. The counter is ADDR_W+1 bits, so termination is unambiguous.

Test Plan:
- Reset, then write each entry i (0..30) with i*64'h0000010204080001 via port 1, then read all 32 on both ports → entry i returns its pattern; entry 31 returns 0.
- we1 to wa1=31 with wd1=64'hA0 → ra=31 reads 0 in the same cycle and after the edge.
- BYPASS=1: wa0=5, wd0=64'h1111 and wa1=5, wd1=64'h2222 both enabled, with ra[0]=5 → rd[0]=64'h2222 combinationally; entry 5 holds 64'h2222 after the edge.
- BYPASS=0: write 64'hDEAD to entry 7 while reading 7 → old value that cycle, 64'hDEAD the next cycle.
- Fill all entries with 64'hFFFF..., pulse clr_req → busy high for exactly 32 cycles; entry k reads 0 from cycle k+2 after the pulse. A write of 64'h55 to entry 10 in the cycle the counter is 10 → entry 10 holds 64'h55.
- reset asserted at clear cycle 6 → busy=0 next cycle and all entries read 0; a clr_req pulse during CLEAR has no effect on busy duration.
